// File: rtl/result_dispatcher_if.sv
// Bundles the FIFO read side and both outbound master channels of the result dispatcher.
// The master modport is the dispatcher's view; slave is the FIFO/master-side view.
interface result_dispatcher_if #(
    parameter int DW = 32
);
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rdata;
    logic [1:0]    fifo_rmode;
    logic [7:0]    fifo_rproc_val;
    logic          fifo_rsrc;

    logic [DW-1:0] mstr0_data;
    logic [1:0]    mstr0_mode;
    logic [7:0]    mstr0_proc_val;
    logic          mstr0_valid;
    logic          mstr0_ready;
    logic          mstr0_cmplt;

    logic [DW-1:0] mstr1_data;
    logic [1:0]    mstr1_mode;
    logic [7:0]    mstr1_proc_val;
    logic          mstr1_valid;
    logic          mstr1_ready;
    logic          mstr1_cmplt;

    logic          disp_err;

    modport master (
        input  fifo_empty, fifo_rdata, fifo_rmode, fifo_rproc_val, fifo_rsrc,
        input  mstr0_ready, mstr1_ready,
        output fifo_rd_en,
        output mstr0_data, mstr0_mode, mstr0_proc_val, mstr0_valid, mstr0_cmplt,
        output mstr1_data, mstr1_mode, mstr1_proc_val, mstr1_valid, mstr1_cmplt,
        output disp_err
    );

    modport slave (
        output fifo_empty, fifo_rdata, fifo_rmode, fifo_rproc_val, fifo_rsrc,
        output mstr0_ready, mstr1_ready,
        input  fifo_rd_en,
        input  mstr0_data, mstr0_mode, mstr0_proc_val, mstr0_valid, mstr0_cmplt,
        input  mstr1_data, mstr1_mode, mstr1_proc_val, mstr1_valid, mstr1_cmplt,
        input  disp_err
    );
endinterface

// File: rtl/result_dispatcher.sv
// Pops merged entries from the shared FIFO and routes each to the master named by its tag,
// pulsing mstrN_cmplt every BURST_LEN accepted words. DISP_ERR_CHK_EN drops mode==00 entries.
//
//  state | meaning
//  IDLE  | waiting for a FIFO entry; pops when not empty
//  LOAD  | FIFO read data valid, captured into holding register
//  SEND  | holding register presented to the tagged master until ready
//  CMPLT | burst of BURST_LEN words finished, cmplt pulse high
module result_dispatcher #(
    parameter int  DW        = 32,
    parameter int  BURST_LEN = 16,
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input logic                 clk,
    input logic                 rst_n,
    result_dispatcher_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        CMPLT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t           state_q, state_d;
    logic [DW-1:0]    data_q, data_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       pv_q, pv_d;
    logic             src_q, src_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic             cmplt0_q, cmplt0_d;
    logic             cmplt1_q, cmplt1_d;
    logic             rd_en;
    logic             sel_ready;
    logic             burst_end;
`ifdef DISP_ERR_CHK_EN
    logic             err_q, err_d;
`endif

    // Ready from the master that does not own the held entry never advances the FSM.
    assign sel_ready = src_q ? bus.mstr1_ready : bus.mstr0_ready;
    assign burst_end = src_q ? (cnt1_q == CNT_LAST) : (cnt0_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        mode_d   = mode_q;
        pv_d     = pv_q;
        src_d    = src_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        cmplt0_d = 1'b0;
        cmplt1_d = 1'b0;
        rd_en    = 1'b0;
`ifdef DISP_ERR_CHK_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = bus.fifo_rdata;
                mode_d  = bus.fifo_rmode;
                pv_d    = bus.fifo_rproc_val;
                src_d   = bus.fifo_rsrc;
                state_d = SEND;
`ifdef DISP_ERR_CHK_EN
                if (bus.fifo_rmode == 2'b00) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            SEND: begin
                if (sel_ready) begin
                    if (burst_end) begin
                        state_d = CMPLT;
                        if (src_q) begin
                            cnt1_d   = '0;
                            cmplt1_d = 1'b1;
                        end else begin
                            cnt0_d   = '0;
                            cmplt0_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        if (src_q) cnt1_d = cnt1_q + CNT_W'(1);
                        else       cnt0_d = cnt0_q + CNT_W'(1);
                    end
                end
            end
            CMPLT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            mode_q   <= '0;
            pv_q     <= '0;
            src_q    <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
            cmplt0_q <= 1'b0;
            cmplt1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            pv_q     <= pv_d;
            src_q    <= src_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
            cmplt0_q <= cmplt0_d;
            cmplt1_q <= cmplt1_d;
        end
    end

`ifdef DISP_ERR_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign bus.disp_err = err_q;
`else
    assign bus.disp_err = 1'b0;
`endif

    assign bus.fifo_rd_en     = rd_en;
    assign bus.mstr0_data     = data_q;
    assign bus.mstr0_mode     = mode_q;
    assign bus.mstr0_proc_val = pv_q;
    assign bus.mstr1_data     = data_q;
    assign bus.mstr1_mode     = mode_q;
    assign bus.mstr1_proc_val = pv_q;
    assign bus.mstr0_valid    = (state_q == SEND) && !src_q;
    assign bus.mstr1_valid    = (state_q == SEND) && src_q;
    assign bus.mstr0_cmplt    = cmplt0_q;
    assign bus.mstr1_cmplt    = cmplt1_q;
endmodule

// File: tb/tb_result_dispatcher.sv
// Scoreboard bench for result_dispatcher: FIFO model feeds entries, per-master expected
// queues are filled at push time and drained by a monitor on every accepted word.
module tb_result_dispatcher;
    localparam int DW = 32;
    localparam int BL = 16;
`ifdef DISP_ERR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic        src;
        logic [31:0] data;
        logic [1:0]  mode;
        logic [7:0]  pv;
    } ent_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  mode;
        logic [7:0]  pv;
        logic        cmplt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_dispatcher_if #(.DW(DW)) bus();
    result_dispatcher #(.DW(DW), .BURST_LEN(BL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    ent_t   fifo_q[$];
    exp_t   exp_q0[$];
    exp_t   exp_q1[$];
    ent_t   last_pop;
    int     tot[2];
    int     cmplt_seen[2];
    int     rdy_mode[2];
    int     drops_exp, errs_seen;
    int     n_cmp, n_fail;
    longint cyc, last_rd_cyc;
    logic   pend;
    logic   arm[2];
    logic   prev_v[2], prev_r[2];
    logic [41:0] prev_d[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expectations follow directly from per-master word totals.
    task automatic push(input logic s, input logic [31:0] d, input logic [1:0] m, input logic [7:0] p);
        ent_t e;
        exp_t x;
        e = '{s, d, m, p};
        fifo_q.push_back(e);
        bus.fifo_empty = 1'b0;
        if (CHK && m == 2'b00) begin
            drops_exp++;
        end else begin
            tot[s]++;
            x = '{d, m, p, (tot[s] % BL) == 0};
            if (s) exp_q1.push_back(x);
            else   exp_q0.push_back(x);
        end
    endtask

    task automatic push_rand(input logic s);
        push(s, $urandom, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs_zero",
              {bus.fifo_rd_en, bus.mstr0_valid, bus.mstr1_valid, bus.mstr0_cmplt, bus.mstr1_cmplt,
               bus.disp_err, bus.mstr0_mode, bus.mstr1_mode, bus.mstr0_proc_val, bus.mstr1_proc_val},
              '0);
        check("reset_data_zero", {bus.mstr0_data, bus.mstr1_data}, '0);
        fifo_q.delete();
        exp_q0.delete();
        exp_q1.delete();
        tot = '{0, 0};
        cmplt_seen = '{0, 0};
        drops_exp = 0;
        errs_seen = 0;
        pend = 1'b0;
        bus.fifo_empty = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int n);
        int k = 0;
        while (!(n == 1 ? bus.mstr1_valid : bus.mstr0_valid) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("wait_valid_timeout", k >= 200, 0);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((fifo_q.size() != 0 || exp_q0.size() != 0 || exp_q1.size() != 0) && k < 4000) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #3;
        check("drain_timeout", k >= 4000, 0);
        check("dropped_entries", errs_seen, drops_exp);
    endtask

    // FIFO model: a pop seen at the negedge is applied just after the next rising edge.
    initial begin : fifo_model
        ent_t e;
        forever begin
            @(posedge clk);
            #1;
            if (pend && rst_n && fifo_q.size() != 0) begin
                e = fifo_q.pop_front();
                last_pop = e;
                bus.fifo_rdata = e.data;
                bus.fifo_rmode = e.mode;
                bus.fifo_rproc_val = e.pv;
                bus.fifo_rsrc = e.src;
                bus.fifo_empty = (fifo_q.size() == 0);
            end
            pend = 1'b0;
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #2;
            bus.mstr0_ready = (rdy_mode[0] == 1) ? 1'b1 : (rdy_mode[0] == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.mstr1_ready = (rdy_mode[1] == 1) ? 1'b1 : (rdy_mode[1] == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    initial begin : monitor
        logic v[2], r[2], c[2], cur_arm[2];
        logic [41:0] cur_d[2];
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = '{1'b0, 1'b0};
                arm = '{1'b0, 1'b0};
                pend = 1'b0;
            end else begin
                cyc++;
                v = '{bus.mstr0_valid, bus.mstr1_valid};
                r = '{bus.mstr0_ready, bus.mstr1_ready};
                c = '{bus.mstr0_cmplt, bus.mstr1_cmplt};
                cur_d[0] = {bus.mstr0_data, bus.mstr0_mode, bus.mstr0_proc_val};
                cur_d[1] = {bus.mstr1_data, bus.mstr1_mode, bus.mstr1_proc_val};
                if (bus.fifo_rd_en) begin
                    check("rd_en_while_empty", bus.fifo_empty, 0);
                    last_rd_cyc = cyc;
                end
                pend = bus.fifo_rd_en;
                if (v[0] || v[1]) check("valid_onehot", v[0] && v[1], 0);
                for (int n = 0; n < 2; n++)
                    if (prev_v[n] && !prev_r[n]) begin
                        check("valid_held_until_ready", v[n], 1);
                        check("payload_held_until_ready", cur_d[n], prev_d[n]);
                    end
                if ((v[0] || v[1]) && !(prev_v[0] || prev_v[1])) begin
                    check("pop_to_valid_latency", cyc - last_rd_cyc, 2);
                    check("valid_routed_to_tag", v[1], last_pop.src);
                end
                cur_arm = arm;
                arm = '{1'b0, 1'b0};
                for (int n = 0; n < 2; n++) begin
                    if (c[n] || cur_arm[n]) check(n == 0 ? "mstr0_cmplt" : "mstr1_cmplt", c[n], cur_arm[n]);
                    if (c[n]) cmplt_seen[n]++;
                end
                if (bus.disp_err) begin
                    errs_seen++;
                    check("disp_err_legal", CHK && last_pop.mode == 2'b00, 1);
                end
                for (int n = 0; n < 2; n++)
                    if (v[n] && r[n]) begin
                        if ((n == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                            check("accept_without_expected_entry", v[n] && r[n], 0);
                        end else begin
                            x = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            check(n == 0 ? "mstr0_payload" : "mstr1_payload", cur_d[n], {x.data, x.mode, x.pv});
                            check("shared_payload_other_master", cur_d[1-n], {x.data, x.mode, x.pv});
                            arm[n] = x.cmplt;
                        end
                    end
                prev_v = v;
                prev_r = r;
                prev_d = cur_d;
            end
        end
    end

    initial begin : stimulus
        n_cmp = 0; n_fail = 0; cyc = 0; last_rd_cyc = 0; pend = 1'b0;
        drops_exp = 0; errs_seen = 0;
        tot = '{0, 0}; cmplt_seen = '{0, 0}; rdy_mode = '{1, 1};
        arm = '{1'b0, 1'b0}; prev_v = '{1'b0, 1'b0}; prev_r = '{1'b0, 1'b0};
        prev_d = '{42'd0, 42'd0};
        last_pop = '0;
        bus.fifo_empty = 1'b1; bus.fifo_rdata = '0; bus.fifo_rmode = '0;
        bus.fifo_rproc_val = '0; bus.fifo_rsrc = 1'b0;
        bus.mstr0_ready = 1'b0; bus.mstr1_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Reset while an entry is held in SEND, then idle with an empty FIFO.
        @(posedge clk); #3;
        rdy_mode[0] = 2;
        push(1'b0, 32'h1234_5678, 2'b10, 8'h11);
        wait_valid(0);
        @(posedge clk); #3;
        do_reset();
        repeat (5) begin
            @(negedge clk);
            check("no_rd_en_after_reset", bus.fifo_rd_en, 0);
        end
        rdy_mode = '{1, 1};

        // Single entry to master 0.
        @(posedge clk); #3;
        push(1'b0, 32'hA5A5_0001, 2'b01, 8'h3C);
        wait_drain();

        // Backpressure on master 1 for five cycles.
        rdy_mode[1] = 2;
        @(posedge clk); #3;
        push(1'b1, 32'hBEEF_0002, 2'b11, 8'h77);
        push(1'b0, 32'h0000_0003, 2'b01, 8'h01);
        wait_valid(1);
        repeat (5) begin
            check("bp_valid_stays", bus.mstr1_valid, 1);
            check("bp_no_extra_pop", bus.fifo_rd_en, 0);
            @(negedge clk);
        end
        rdy_mode[1] = 1;
        wait_drain();

        // Full burst of 16 plus one extra word on master 0.
        @(posedge clk); #3;
        do_reset();
        for (int i = 0; i < BL + 1; i++) push(1'b0, 32'h0100_0000 + 32'(i), 2'b01, 8'(i));
        wait_drain();
        check("burst_cmplt0_pulses", cmplt_seen[0], 1);
        check("burst_cmplt1_pulses", cmplt_seen[1], 0);

        // Interleaved tags: 15 to master 0, 16 to master 1, 1 to master 0.
        do_reset();
        @(posedge clk); #3;
        for (int i = 0; i < BL - 1; i++) push(1'b0, 32'h0200_0000 + 32'(i), 2'b10, 8'(i));
        for (int i = 0; i < BL; i++)     push(1'b1, 32'h0300_0000 + 32'(i), 2'b11, 8'(i));
        push(1'b0, 32'h0400_0000, 2'b01, 8'hFF);
        wait_drain();
        check("interleave_cmplt0_pulses", cmplt_seen[0], 1);
        check("interleave_cmplt1_pulses", cmplt_seen[1], 1);

        // Entry with mode 00: dropped with disp_err or forwarded, depending on the build.
        @(posedge clk); #3;
        push(1'b0, 32'hDEAD_0006, 2'b00, 8'h66);
        push(1'b1, 32'hDEAD_0007, 2'b01, 8'h67);
        wait_drain();
        check("mode00_err_count", errs_seen, CHK ? 1 : 0);

        // Randomized traffic with random backpressure on both masters.
        rdy_mode = '{0, 0};
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #3;
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 3)) push_rand(1'($urandom_range(0, 1)));
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
